// File: rtl/debounce_bank.sv
// Multi-channel debouncer: per-channel synchroniser, disagreement counter, level and edge pulses.
// Define DEBOUNCE_BANK_REPEAT_EN to build the hold auto-repeat FSMs driving btn_repeat.
module debounce_bank #(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2,
    parameter int ACTIVE_LOW      = 0,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] btn_raw,
    output logic [CHANNELS-1:0] btn_level,
    output logic [CHANNELS-1:0] btn_rise,
    output logic [CHANNELS-1:0] btn_fall,
    output logic [CHANNELS-1:0] btn_repeat
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CHANNELS-1:0] POLARITY = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [SYNC_STAGES-1:0] sync_q [CHANNELS];
    logic [CW-1:0]          cnt_q  [CHANNELS];
    logic [CHANNELS-1:0]    s;
    logic [CHANNELS-1:0]    accept;
    logic [CHANNELS-1:0]    rise_evt;
    logic [CHANNELS-1:0]    fall_evt;

    always_comb begin
        s      = '0;
        accept = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            s[i]      = sync_q[i][SYNC_STAGES-1];
            accept[i] = (s[i] != btn_level[i]) && (cnt_q[i] == CNT_LAST);
        end
        rise_evt = accept & s;
        fall_evt = accept & ~s;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                sync_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            btn_level <= '0;
            btn_rise  <= '0;
            btn_fall  <= '0;
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], btn_raw[i] ^ POLARITY[i]};
                // any agreeing sample restarts the count, so it never wraps
                if (s[i] != btn_level[i])
                    cnt_q[i] <= accept[i] ? '0 : cnt_q[i] + 1'b1;
                else
                    cnt_q[i] <= '0;
            end
            btn_level <= btn_level ^ accept;
            btn_rise  <= rise_evt;
            btn_fall  <= fall_evt;
        end
    end

`ifdef DEBOUNCE_BANK_REPEAT_EN
    localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HW   = $clog2(HMAX + 1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] REPEAT_LAST = HW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_REPEAT
    } rpt_state_t;

    rpt_state_t      state_q [CHANNELS];
    logic [HW-1:0]   hcnt_q  [CHANNELS];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                state_q[i] <= ST_IDLE;
                hcnt_q[i]  <= '0;
            end
            btn_repeat <= '0;
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                btn_repeat[i] <= 1'b0;
                // a release wins over a repeat pulse due in the same cycle
                if (fall_evt[i]) begin
                    state_q[i] <= ST_IDLE;
                    hcnt_q[i]  <= '0;
                end else begin
                    case (state_q[i])
                        ST_IDLE: begin
                            if (rise_evt[i]) begin
                                state_q[i] <= ST_HOLD;
                                hcnt_q[i]  <= '0;
                            end
                        end
                        ST_HOLD: begin
                            if (hcnt_q[i] == HOLD_LAST) begin
                                btn_repeat[i] <= 1'b1;
                                state_q[i]    <= ST_REPEAT;
                                hcnt_q[i]     <= '0;
                            end else begin
                                hcnt_q[i] <= hcnt_q[i] + 1'b1;
                            end
                        end
                        ST_REPEAT: begin
                            if (hcnt_q[i] == REPEAT_LAST) begin
                                btn_repeat[i] <= 1'b1;
                                hcnt_q[i]     <= '0;
                            end else begin
                                hcnt_q[i] <= hcnt_q[i] + 1'b1;
                            end
                        end
                        default: begin
                            state_q[i] <= ST_IDLE;
                            hcnt_q[i]  <= '0;
                        end
                    endcase
                end
            end
        end
    end
`else
    // repeat timing parameters have no effect here; the expression is constant zero
    assign btn_repeat = {CHANNELS{(HOLD_CYCLES < 1) && (REPEAT_CYCLES < 1) && 1'b0}};
`endif

endmodule

// File: tb/tb_debounce_bank.sv
// Directed self-checking bench for debounce_bank (4 channels, 4-sample debounce, 2 sync stages).
module tb_debounce_bank;

    logic       clk;
    logic       reset;
    logic [3:0] btn_raw;
    logic [3:0] btn_level;
    logic [3:0] btn_rise;
    logic [3:0] btn_fall;
    logic [3:0] btn_repeat;

    int passed;
    int total;

`ifdef DEBOUNCE_BANK_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    debounce_bank #(
        .CHANNELS(4),
        .DEBOUNCE_CYCLES(4),
        .SYNC_STAGES(2),
        .ACTIVE_LOW(0),
        .HOLD_CYCLES(8),
        .REPEAT_CYCLES(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_raw(btn_raw),
        .btn_level(btn_level),
        .btn_rise(btn_rise),
        .btn_fall(btn_fall),
        .btn_repeat(btn_repeat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [11:0] exp;
        reset   = 1'b0;
        btn_raw = 4'hF;
        cyc(3);
        total++;
        if ({btn_level, btn_rise, btn_fall, btn_repeat} !== 16'h0)
            $display("FAIL reset_outputs: got %h expected 0000",
                     {btn_level, btn_rise, btn_fall, btn_repeat});
        else passed++;
        reset = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cyc(1);
            exp = {(k >= 6) ? 4'hF : 4'h0, (k == 6) ? 4'hF : 4'h0, 4'h0};
            total++;
            if ({btn_level, btn_rise, btn_fall} !== exp)
                $display("FAIL reset_release k=%0d: got %h expected %h", k,
                         {btn_level, btn_rise, btn_fall}, exp);
            else passed++;
        end
        btn_raw = 4'h0;
        cyc(10);
        total++;
        if (btn_level !== 4'h0)
            $display("FAIL reset_settle_low: got %h expected 0", btn_level);
        else passed++;
    endtask

    task automatic test_edges();
        logic [11:0] exp;
        btn_raw = 4'b0001;
        for (int k = 1; k <= 8; k++) begin
            cyc(1);
            exp = {(k >= 6) ? 4'b0001 : 4'b0000, (k == 6) ? 4'b0001 : 4'b0000, 4'b0000};
            total++;
            if ({btn_level, btn_rise, btn_fall} !== exp)
                $display("FAIL edge_rise k=%0d: got %h expected %h", k,
                         {btn_level, btn_rise, btn_fall}, exp);
            else passed++;
        end
        btn_raw = 4'b0000;
        for (int k = 1; k <= 8; k++) begin
            cyc(1);
            exp = {(k < 6) ? 4'b0001 : 4'b0000, 4'b0000, (k == 6) ? 4'b0001 : 4'b0000};
            total++;
            if ({btn_level, btn_rise, btn_fall} !== exp)
                $display("FAIL edge_fall k=%0d: got %h expected %h", k,
                         {btn_level, btn_rise, btn_fall}, exp);
            else passed++;
        end
    endtask

    task automatic test_glitch();
        logic [11:0] exp;
        logic [5:0]  pat;
        // 3-sample glitch: rejected
        for (int k = 1; k <= 10; k++) begin
            btn_raw = (k <= 3) ? 4'b0010 : 4'b0000;
            cyc(1);
            total++;
            if ({btn_level, btn_rise, btn_fall} !== 12'h0)
                $display("FAIL glitch3 k=%0d: got %h expected 000", k,
                         {btn_level, btn_rise, btn_fall});
            else passed++;
        end
        // 4-sample glitch: accepted, then released 4 samples later
        for (int k = 1; k <= 12; k++) begin
            btn_raw = (k <= 4) ? 4'b0010 : 4'b0000;
            cyc(1);
            exp = {(k >= 6 && k <= 9) ? 4'b0010 : 4'b0000,
                   (k == 6) ? 4'b0010 : 4'b0000,
                   (k == 10) ? 4'b0010 : 4'b0000};
            total++;
            if ({btn_level, btn_rise, btn_fall} !== exp)
                $display("FAIL glitch4 k=%0d: got %h expected %h", k,
                         {btn_level, btn_rise, btn_fall}, exp);
            else passed++;
        end
        // bounce 1,0,1,1,1,1: count restarts after the 0
        pat = 6'b111101;
        for (int k = 1; k <= 10; k++) begin
            btn_raw = {2'b00, (k <= 6) ? pat[k-1] : 1'b1, 1'b0};
            cyc(1);
            exp = {(k >= 8) ? 4'b0010 : 4'b0000, (k == 8) ? 4'b0010 : 4'b0000, 4'b0000};
            total++;
            if ({btn_level, btn_rise, btn_fall} !== exp)
                $display("FAIL bounce k=%0d: got %h expected %h", k,
                         {btn_level, btn_rise, btn_fall}, exp);
            else passed++;
        end
        btn_raw = 4'b0000;
        cyc(10);
    endtask

    task automatic test_simultaneous();
        logic [11:0] exp;
        btn_raw = 4'b0001;
        cyc(10);
        btn_raw = 4'b1100;
        for (int k = 1; k <= 8; k++) begin
            cyc(1);
            exp = {(k >= 6) ? 4'b1100 : 4'b0001,
                   (k == 6) ? 4'b1100 : 4'b0000,
                   (k == 6) ? 4'b0001 : 4'b0000};
            total++;
            if ({btn_level, btn_rise, btn_fall} !== exp)
                $display("FAIL simultaneous k=%0d: got %h expected %h", k,
                         {btn_level, btn_rise, btn_fall}, exp);
            else passed++;
        end
    endtask

    task automatic test_reset_midcount();
        logic [11:0] exp;
        btn_raw = 4'b1101;
        for (int k = 1; k <= 4; k++) begin
            cyc(1);
            total++;
            if ({btn_level, btn_rise, btn_fall} !== {4'b1100, 8'h00})
                $display("FAIL midcount_pre k=%0d: got %h expected c00", k,
                         {btn_level, btn_rise, btn_fall});
            else passed++;
        end
        reset = 1'b0;
        cyc(1);
        total++;
        if ({btn_level, btn_rise, btn_fall, btn_repeat} !== 16'h0)
            $display("FAIL midcount_reset: got %h expected 0000",
                     {btn_level, btn_rise, btn_fall, btn_repeat});
        else passed++;
        reset = 1'b1;
        for (int k = 6; k <= 13; k++) begin
            cyc(1);
            exp = {(k >= 11) ? 4'b1101 : 4'b0000, (k == 11) ? 4'b1101 : 4'b0000, 4'b0000};
            total++;
            if ({btn_level, btn_rise, btn_fall} !== exp)
                $display("FAIL midcount_recount k=%0d: got %h expected %h", k,
                         {btn_level, btn_rise, btn_fall}, exp);
            else passed++;
        end
    endtask

    task automatic test_repeat();
        logic [11:0] exp;
        logic [3:0]  exp_rep;
        btn_raw = 4'b0000;
        cyc(12);
        for (int k = 1; k <= 40; k++) begin
            btn_raw = (k <= 20) ? 4'b0001 : 4'b0000;
            cyc(1);
            exp = {(k >= 6 && k <= 25) ? 4'b0001 : 4'b0000,
                   (k == 6) ? 4'b0001 : 4'b0000,
                   (k == 26) ? 4'b0001 : 4'b0000};
            exp_rep = (REP && (k == 14 || k == 17 || k == 20 || k == 23)) ? 4'b0001 : 4'b0000;
            total++;
            if ({btn_level, btn_rise, btn_fall} !== exp)
                $display("FAIL hold_edges k=%0d: got %h expected %h", k,
                         {btn_level, btn_rise, btn_fall}, exp);
            else passed++;
            total++;
            if (btn_repeat !== exp_rep)
                $display("FAIL repeat k=%0d: got %h expected %h", k, btn_repeat, exp_rep);
            else passed++;
        end
    endtask

    initial begin
        passed  = 0;
        total   = 0;
        reset   = 1'b0;
        btn_raw = 4'h0;
        test_reset();
        test_edges();
        test_glitch();
        test_simultaneous();
        test_reset_midcount();
        test_repeat();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
